hazard_ctrl: RTL

- Pipeline control block for the 5-stage RV32I core.
- It is the reverse-direction counterpart of the stage registers. It consumes the Rd/RegWrite/ResultSrc fields that those registers carry forward, and returns stall/flush enables to them plus forwarding selects to the execute stage.
- It also owns a data-memory wait FSM with timeout detection and stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 45 ++++
 rtl/hazard_ctrl_if.sv | 65 ++++++
 rtl/hazard_ctrl_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared pipeline-control types for the 5-stage RV32I core:
//            forwarding selects, memory-wait FSM states and the x0 index.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Operand source selected by the Execute-stage forwarding muxes
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,   // value read from the register file in Decode
    FWD_W  = 2'b01,   // ResultW from the Writeback stage
    FWD_M  = 2'b10    // ALUResultM from the Memory stage
  } fwd_sel_t;

  // Data-memory wait FSM
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

  // x0 is hard-wired to zero, so it never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Pick the youngest in-flight producer of a source register.
  // Memory holds the more recent write, so it wins over Writeback.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       regwrite_m,
    input logic [4:0] rd_w,
    input logic       regwrite_w
  );
    if (regwrite_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
      return FWD_M;
    end else if (regwrite_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
      return FWD_W;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Bundle between the pipeline stage registers and the hazard
//            controller. The pipeline side (master) supplies register
//            indices and memory status; the controller side (slave) returns
//            stall/flush enables, forwarding selects and status counters.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);

  // Decode stage
  logic [4:0]           Rs1D;
  logic [4:0]           Rs2D;
  // Execute stage
  logic [4:0]           Rs1E;
  logic [4:0]           Rs2E;
  logic [4:0]           RdE;
  logic                 ResultSrcE;
  logic                 PCSrcE;
  // Memory stage
  logic [4:0]           RdM;
  logic                 RegWriteM;
  logic                 MemReqM;
  logic                 MemReadyM;
  // Writeback stage
  logic [4:0]           RdW;
  logic                 RegWriteW;

  // Controls returned to the stage registers
  logic                 StallF;
  logic                 StallD;
  logic                 StallE;
  logic                 StallM;
  logic                 FlushD;
  logic                 FlushE;
  logic                 FlushW;
  logic [1:0]           ForwardAE;
  logic [1:0]           ForwardBE;

  // Status
  logic                 MemTimeout;
  logic [CNT_WIDTH-1:0] StallCount;
  logic [CNT_WIDTH-1:0] FlushCount;

  // Pipeline datapath side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    output RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeout, StallCount, FlushCount
  );

  // Hazard controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    input  RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeout, StallCount, FlushCount
  );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at MAX_VAL instead of wrapping.
//            Synchronous clear has priority over increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             en,
  output      logic [WIDTH-1:0] count
);

  // Count enabled cycles, clamped at MAX_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Reverse-direction control for the 5-stage RV32I pipeline.
//            Produces operand forwarding selects, stage stall/flush enables
//            (memory wait > taken branch > load-use), a data-memory wait FSM
//            with sticky timeout, and saturating stall/flush counters.
//            The interface instance must carry the same CNT_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_LIMIT = 64
) (
  input wire logic    clk,
  input wire logic    rst_n,
  hazard_ctrl_if.slave hz
);

  // Wide enough to hold WAIT_LIMIT itself
  localparam int                  c_WAIT_W   = $clog2(WAIT_LIMIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(WAIT_LIMIT);

  logic                w_memwait;
  logic                w_loaduse;
  logic                w_wait_clr;
  logic                w_wait_en;
  logic [c_WAIT_W-1:0] w_wait_cnt;
  hz_state_t           r_state;
  logic                r_timeout;

  // A pending memory access stalls the whole pipe in the very cycle it misses
  assign w_memwait = hz.MemReqM && !hz.MemReadyM;

  // A load in Execute whose destination is read by the instruction in Decode
  assign w_loaduse = hz.ResultSrcE && (hz.RdE != REG_ZERO) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Operand bypass selects for the two Execute-stage ALU inputs
  assign hz.ForwardAE = fwd_select(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_select(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

  // Stall/flush arbitration; a branch seen during a memory wait is simply
  // held in Execute and resolves once the wait releases
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (w_memwait) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (w_loaduse) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  // Memory-wait FSM plus sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN:     if (w_memwait)    r_state <= WAIT;
        WAIT:    if (hz.MemReadyM) r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (w_wait_cnt == c_WAIT_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign hz.MemTimeout = r_timeout;

  // Wait counter restarts on each RUN->WAIT transition and ticks in WAIT
  assign w_wait_clr = (r_state == RUN) && w_memwait;
  assign w_wait_en  = (r_state == WAIT);

  sat_counter #(
    .WIDTH   (c_WAIT_W),
    .MAX_VAL (c_WAIT_MAX)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_wait_clr),
    .en    (w_wait_en),
    .count (w_wait_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (hz.StallF),
    .count (hz.StallCount)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (hz.FlushE),
    .count (hz.FlushCount)
  );

endmodule
`default_nettype wire
